// File: rtl/uart_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_link_ctrl
// Description : Link controller between the game state machine and a byte-level
//               UART. Shares the single transmitter between the ready beacon
//               (0x52, periodic while in WAIT) and the score report
//               (0x53, score[15:8], score[7:0]). Parses received peer bytes
//               into a peer-ready flag and the peer's score.
// Ports       :
//   pclk             in   1   system clock, rising edge
//   rst_d            in   1   asynchronous active-high reset
//   state            in   2   game state: IDLE=00 WAIT=01 GAME=10 SCORE=11
//   score            in  16   local score, snapshotted at score-message launch
//   tx_busy          in   1   UART transmitter busy level
//   tx_start         out  1   one-cycle request to send tx_data
//   tx_data          out  8   byte to send, stable until tx_busy falls
//   rx_done          in   1   one-cycle strobe, rx_data valid
//   rx_data          in   8   received byte
//   uart_start       out  1   peer ready while local state is WAIT
//   peer_score       out 16   last complete score received from the peer
//   peer_score_valid out  1   peer_score received since the last IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_link_ctrl #(
  parameter int unsigned BEACON_PERIOD = 6_500_000
) (
  input  logic        pclk,
  input  logic        rst_d,
  input  logic [1:0]  state,
  input  logic [15:0] score,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        uart_start,
  output logic [15:0] peer_score,
  output logic        peer_score_valid
);

  // Game states that this block reacts to (GAME needs no special handling).
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_SCORE = 2'b11;

  localparam logic [7:0] MSG_BEACON = 8'h52;
  localparam logic [7:0] MSG_SCORE  = 8'h53;

  localparam int unsigned      CNT_W    = $clog2(BEACON_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEACON_PERIOD - 1);

  // TX FSM encoding
  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_START = 2'd1;
  localparam logic [1:0] T_BUSY  = 2'd2;
  localparam logic [1:0] T_DONE  = 2'd3;

  // RX parser encoding
  localparam logic [1:0] R_HDR = 2'd0;
  localparam logic [1:0] R_HI  = 2'd1;
  localparam logic [1:0] R_LO  = 2'd2;

  // --------------------------------------------------------------------------
  // Flops
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,       state_d;
  logic [CNT_W-1:0] beacon_cnt_q,  beacon_cnt_d;
  logic             beacon_req_q,  beacon_req_d;
  logic             score_req_q,   score_req_d;
  logic             tx_busy_q;
  logic [1:0]       tx_state_q,    tx_state_d;
  logic             msg_score_q,   msg_score_d;
  logic [1:0]       byte_idx_q,    byte_idx_d;
  logic [15:0]      snap_q,        snap_d;
  logic             tx_start_q,    tx_start_d;
  logic [7:0]       tx_data_q,     tx_data_d;
  logic [1:0]       rx_state_q,    rx_state_d;
  logic [7:0]       hi_q,          hi_d;
  logic             peer_ready_q,  peer_ready_d;
  logic             uart_start_q,  uart_start_d;
  logic [15:0]      peer_score_q,  peer_score_d;
  logic             psv_q,         psv_d;

  // --------------------------------------------------------------------------
  // Request generation
  // --------------------------------------------------------------------------
  logic entry;
  logic in_wait;
  logic beacon_wrap;
  logic launch_score;
  logic launch_beacon;
  logic more_bytes;

  assign state_d     = state;
  assign entry       = (state != state_q);
  assign in_wait     = (state == ST_WAIT);
  assign beacon_wrap = in_wait && !entry && (beacon_cnt_q == CNT_LAST);

  // Arbitration only in T_IDLE, i.e. between messages; SCORE wins.
  // A beacon is only launched while still in WAIT so a request left over
  // from the cycle WAIT was exited never escapes.
  assign launch_score  = (tx_state_q == T_IDLE) && score_req_q;
  assign launch_beacon = (tx_state_q == T_IDLE) && !score_req_q &&
                         beacon_req_q && in_wait;

  // Only the score message has bytes after the header.
  assign more_bytes = msg_score_q && (byte_idx_q != 2'd2);

  always_comb begin
    beacon_cnt_d = beacon_cnt_q + CNT_W'(1);
    if (!in_wait || entry || beacon_wrap) begin
      beacon_cnt_d = '0;
    end
  end

  always_comb begin
    beacon_req_d = beacon_req_q;
    if (launch_beacon) begin
      beacon_req_d = 1'b0;
    end
    // A fresh trigger in the launch cycle represents a new beacon.
    if (in_wait && (entry || beacon_wrap)) begin
      beacon_req_d = 1'b1;
    end
    if (!in_wait) begin
      beacon_req_d = 1'b0;
    end
  end

  always_comb begin
    score_req_d = score_req_q;
    if (launch_score) begin
      score_req_d = 1'b0;
    end
    if (entry && (state == ST_SCORE)) begin
      score_req_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // TX FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk or posedge rst_d) begin
    if (rst_d) begin
      tx_state_q <= T_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  // TX FSM: next state. tx_busy is registered first, so the falling edge is
  // acted on one cycle after it appears on the port.
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      T_IDLE:  if (launch_score || launch_beacon) tx_state_d = T_START;
      T_START: tx_state_d = T_BUSY;
      T_BUSY:  if (tx_busy_q) tx_state_d = T_DONE;
      T_DONE:  if (!tx_busy_q) tx_state_d = more_bytes ? T_START : T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX FSM: outputs. tx_start is high exactly while the FSM sits in T_START.
  always_comb begin
    tx_start_d  = (tx_state_d == T_START);
    tx_data_d   = tx_data_q;
    msg_score_d = msg_score_q;
    byte_idx_d  = byte_idx_q;
    snap_d      = snap_q;
    if (launch_score) begin
      tx_data_d   = MSG_SCORE;
      msg_score_d = 1'b1;
      byte_idx_d  = 2'd0;
      snap_d      = score;
    end else if (launch_beacon) begin
      tx_data_d   = MSG_BEACON;
      msg_score_d = 1'b0;
      byte_idx_d  = 2'd0;
    end else if ((tx_state_q == T_DONE) && !tx_busy_q && more_bytes) begin
      byte_idx_d = byte_idx_q + 2'd1;
      tx_data_d  = (byte_idx_q == 2'd0) ? snap_q[15:8] : snap_q[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // RX parser: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk or posedge rst_d) begin
    if (rst_d) begin
      rx_state_q <= R_HDR;
    end else begin
      rx_state_q <= rx_state_d;
    end
  end

  // RX parser: next state. Payload bytes are taken verbatim, even 0x52/0x53.
  always_comb begin
    rx_state_d = rx_state_q;
    if (rx_done) begin
      case (rx_state_q)
        R_HDR:   if (rx_data == MSG_SCORE) rx_state_d = R_HI;
        R_HI:    rx_state_d = R_LO;
        R_LO:    rx_state_d = R_HDR;
        default: rx_state_d = R_HDR;
      endcase
    end
  end

  // RX parser: outputs. Leaving WAIT / entering IDLE override same-cycle bytes.
  always_comb begin
    hi_d         = hi_q;
    peer_ready_d = peer_ready_q;
    peer_score_d = peer_score_q;
    psv_d        = psv_q;
    if (rx_done) begin
      case (rx_state_q)
        R_HDR: if (rx_data == MSG_BEACON) peer_ready_d = 1'b1;
        R_HI:  hi_d = rx_data;
        R_LO: begin
          peer_score_d = {hi_q, rx_data};
          psv_d        = 1'b1;
        end
        default: hi_d = hi_q;
      endcase
    end
    if (!in_wait) begin
      peer_ready_d = 1'b0;
    end
    if (state == ST_IDLE) begin
      psv_d = 1'b0;
    end
    uart_start_d = peer_ready_q && in_wait;
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge pclk or posedge rst_d) begin
    if (rst_d) begin
      state_q      <= ST_SCORE;
      beacon_cnt_q <= '0;
      beacon_req_q <= 1'b0;
      score_req_q  <= 1'b0;
      tx_busy_q    <= 1'b0;
      msg_score_q  <= 1'b0;
      byte_idx_q   <= 2'd0;
      snap_q       <= 16'h0000;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      hi_q         <= 8'h00;
      peer_ready_q <= 1'b0;
      uart_start_q <= 1'b0;
      peer_score_q <= 16'h0000;
      psv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beacon_cnt_q <= beacon_cnt_d;
      beacon_req_q <= beacon_req_d;
      score_req_q  <= score_req_d;
      tx_busy_q    <= tx_busy;
      msg_score_q  <= msg_score_d;
      byte_idx_q   <= byte_idx_d;
      snap_q       <= snap_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      hi_q         <= hi_d;
      peer_ready_q <= peer_ready_d;
      uart_start_q <= uart_start_d;
      peer_score_q <= peer_score_d;
      psv_q        <= psv_d;
    end
  end

  assign tx_start         = tx_start_q;
  assign tx_data          = tx_data_q;
  assign uart_start       = uart_start_q;
  assign peer_score       = peer_score_q;
  assign peer_score_valid = psv_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_link_ctrl
// Description : Self-checking bench for uart_link_ctrl. A UART model answers
//               each tx_start with a busy window; transmitted bytes are logged
//               with their cycle numbers and compared against message
//               schedules computed from the link rules. Received bytes are
//               checked against a byte-level model of the peer protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_link_ctrl;

  localparam int unsigned P = 50;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_WAIT  = 2'b01;
  localparam logic [1:0] S_GAME  = 2'b10;
  localparam logic [1:0] S_SCORE = 2'b11;

  logic        pclk = 1'b0;
  logic        rst_d = 1'b1;
  logic [1:0]  state = S_IDLE;
  logic [15:0] score = 16'h0000;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        uart_start;
  logic [15:0] peer_score;
  logic        peer_score_valid;

  uart_link_ctrl #(.BEACON_PERIOD(P)) dut (
    .pclk             (pclk),
    .rst_d            (rst_d),
    .state            (state),
    .score            (score),
    .tx_busy          (tx_busy),
    .tx_start         (tx_start),
    .tx_data          (tx_data),
    .rx_done          (rx_done),
    .rx_data          (rx_data),
    .uart_start       (uart_start),
    .peer_score       (peer_score),
    .peer_score_valid (peer_score_valid)
  );

  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- UART TX model and transmit log ----------------
  int unsigned busy_len = 10;
  int unsigned busy_cnt = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  held_byte = 8'h00;
  int unsigned ev_cyc[$];
  logic [7:0]  ev_byte[$];
  int unsigned x_cyc[$];
  logic [7:0]  x_byte[$];

  always @(negedge pclk) begin
    if (rst_d) begin
      busy_cnt   = 0;
      tx_busy    = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (tx_busy) check_eq("tx_data_hold", {24'h0, tx_data}, {24'h0, held_byte});
      if (busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy = 1'b0;
      end
      if (tx_start) begin
        check_eq("tx_start_pulse", {31'h0, prev_start}, 32'h0);
        ev_cyc.push_back(cyc);
        ev_byte.push_back(tx_data);
        held_byte = tx_data;
        busy_cnt  = busy_len;
      end
      prev_start = tx_start;
    end
  end

  // Bytes of one message leave busy_len+3 cycles apart: busy falls
  // busy_len+1 cycles after tx_start and the next start follows 2 cycles later.
  task automatic add_msg(input int unsigned t0, input logic is_score, input logic [15:0] s);
    int unsigned gap;
    gap = busy_len + 3;
    if (is_score) begin
      x_cyc.push_back(t0);         x_byte.push_back(8'h53);
      x_cyc.push_back(t0 + gap);   x_byte.push_back(s[15:8]);
      x_cyc.push_back(t0 + 2*gap); x_byte.push_back(s[7:0]);
    end else begin
      x_cyc.push_back(t0);         x_byte.push_back(8'h52);
    end
  endtask

  task automatic check_tx(input string name);
    check_eq({name, "_count"}, ev_cyc.size(), x_cyc.size());
    for (int i = 0; i < x_cyc.size() && i < ev_cyc.size(); i++) begin
      check_eq($sformatf("%s_cyc%0d", name, i), ev_cyc[i], x_cyc[i]);
      check_eq($sformatf("%s_byte%0d", name, i), {24'h0, ev_byte[i]}, {24'h0, x_byte[i]});
    end
    ev_cyc.delete(); ev_byte.delete();
    x_cyc.delete();  x_byte.delete();
  endtask

  // ---------------- peer protocol model ----------------
  logic        m_ready  = 1'b0;
  int          m_phase  = 0;
  logic [7:0]  m_hi     = 8'h00;
  logic [15:0] m_pscore = 16'h0000;
  logic        m_valid  = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic set_state(input logic [1:0] s);
    state = s;
    if (s != S_WAIT) m_ready = 1'b0;
    if (s == S_IDLE) m_valid = 1'b0;
  endtask

  // Sends one byte while applying game state s_new in the same cycle.
  task automatic send_rx(input logic [7:0] b, input logic [1:0] s_new);
    logic old;
    old = m_ready && (s_new == S_WAIT);
    set_state(s_new);
    rx_done = 1'b1;
    rx_data = b;
    case (m_phase)
      0: begin
        if (b == 8'h52) begin
          if (s_new == S_WAIT) m_ready = 1'b1;
        end else if (b == 8'h53) begin
          m_phase = 1;
        end
      end
      1: begin
        m_hi    = b;
        m_phase = 2;
      end
      default: begin
        m_pscore = {m_hi, b};
        if (s_new != S_IDLE) m_valid = 1'b1;
        m_phase = 0;
      end
    endcase
    @(negedge pclk);
    rx_done = 1'b0;
    check_eq("uart_start_m1", {31'h0, uart_start}, {31'h0, old});
    @(negedge pclk);
    check_eq("uart_start", {31'h0, uart_start}, {31'h0, (m_ready && state == S_WAIT)});
    check_eq("peer_score", {16'h0, peer_score}, {16'h0, m_pscore});
    check_eq("peer_score_valid", {31'h0, peer_score_valid}, {31'h0, m_valid});
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_tx_start"}, {31'h0, tx_start}, 32'h0);
    check_eq({pfx, "_tx_data"}, {24'h0, tx_data}, 32'h0);
    check_eq({pfx, "_uart_start"}, {31'h0, uart_start}, 32'h0);
    check_eq({pfx, "_peer_score"}, {16'h0, peer_score}, 32'h0);
    check_eq({pfx, "_peer_score_valid"}, {31'h0, peer_score_valid}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  int unsigned n0;
  int unsigned stay;
  logic [15:0] s;
  logic [7:0]  b;
  int          r;
  int          k;
  logic        found;

  initial begin
    tick(3);
    check_reset_outputs("reset");
    rst_d = 1'b0;
    tick(4);

    // Beacons in WAIT: first at entry+2, then every P cycles, none after GAME.
    busy_len = $urandom_range(3, 12);
    n0 = cyc;
    set_state(S_WAIT);
    stay = 3*P + 20 + $urandom_range(0, 20);
    tick(stay);
    set_state(S_GAME);
    for (int i = 0; i < 4; i++) add_msg(n0 + 2 + i*P, 1'b0, 16'h0);
    tick(3*P);
    check_tx("beacon");

    // Score message; score changes mid-message must not leak in.
    for (int it = 0; it < 2; it++) begin
      busy_len = $urandom_range(3, 12);
      s = (it == 0) ? 16'h1234 : 16'($urandom);
      n0 = cyc;
      score = s;
      set_state(S_SCORE);
      tick(3);
      score = 16'hFFFF;
      add_msg(n0 + 2, 1'b1, s);
      tick(60);
      check_tx($sformatf("score%0d", it));
      set_state(S_GAME);
      tick(5);
    end

    // Beacon in flight, second beacon pending, then SCORE entered.
    busy_len = $urandom_range(3, 12);
    s = 16'($urandom);
    score = s;
    n0 = cyc;
    set_state(S_WAIT);
    tick(3); set_state(S_GAME);
    tick(1); set_state(S_WAIT);
    tick(1); set_state(S_SCORE);
    add_msg(n0 + 2, 1'b0, 16'h0);
    add_msg(n0 + 2 + busy_len + 4, 1'b1, s);
    tick(100);
    check_tx("preempt");

    // Peer ready handshake in WAIT.
    set_state(S_WAIT);
    tick(2);
    send_rx(8'h41, S_WAIT);
    tick(1);
    do b = 8'($urandom); while (b == 8'h52 || b == 8'h53);
    send_rx(b, S_WAIT);
    send_rx(8'h52, S_WAIT);
    tick(2);
    check_eq("uart_start_held", {31'h0, uart_start}, {31'h0, (m_ready && state == S_WAIT)});
    set_state(S_GAME);
    tick(1);
    check_eq("uart_start_exit", {31'h0, uart_start}, {31'h0, m_ready});
    // Ready byte in the same cycle WAIT is left must not stick.
    set_state(S_WAIT);
    tick(2);
    send_rx(8'h52, S_GAME);
    set_state(S_WAIT);
    tick(3);
    check_eq("uart_start_no_stale", {31'h0, uart_start}, 32'h0);

    // Random peer traffic outside WAIT.
    set_state(S_GAME);
    tick(1);
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 3);
      b = (r == 0) ? 8'h53 : (r == 1) ? 8'h52 : 8'($urandom);
      send_rx(b, S_GAME);
      if ($urandom_range(0, 1) == 1) tick(1);
    end
    k = 0;
    while (m_phase != 0 && k < 4) begin
      send_rx(8'($urandom), S_GAME);
      k++;
    end
    send_rx(8'h53, S_GAME);
    send_rx(8'h00, S_GAME);
    send_rx(8'h2A, S_GAME);
    check_eq("peer_score_002a", {16'h0, peer_score}, 32'h0000_002A);
    set_state(S_IDLE);
    tick(1);
    check_eq("valid_idle", {31'h0, peer_score_valid}, {31'h0, m_valid});
    check_eq("score_kept", {16'h0, peer_score}, {16'h0, m_pscore});
    set_state(S_GAME);
    tick(1);
    send_rx(8'h53, S_GAME);
    send_rx(8'h11, S_GAME);
    send_rx(8'h22, S_IDLE);

    // Reset during the second byte of a score message.
    busy_len = $urandom_range(3, 12);
    tick(20);
    s = 16'($urandom);
    score = s;
    set_state(S_SCORE);
    k = 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge pclk);
      if (tx_start) begin
        k++;
        if (k == 2) found = 1'b1;
      end
    end
    check_eq("second_byte_seen", {31'h0, found}, 32'h1);
    check_eq("second_byte_data", {24'h0, tx_data}, {24'h0, s[15:8]});
    #1 rst_d = 1'b1;
    #1;
    check_reset_outputs("midreset");
    m_ready = 1'b0; m_phase = 0; m_hi = 8'h00; m_pscore = 16'h0; m_valid = 1'b0;
    tick(2);
    rst_d = 1'b0;
    ev_cyc.delete();
    ev_byte.delete();
    tick(80);
    check_tx("no_resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
